// File: rtl/sdram_init_ctrl.sv
// sdram_init_ctrl
// Power-up initialisation sequencer for a 16-bit, 4-bank SDR SDRAM.
// After reset it waits T_POWER clocks, then issues PRECHARGE ALL, REF_NUM
// AUTO REFRESH commands and LOAD MODE REGISTER, each followed by its NOP gap,
// and finally raises o_init_done (level, held until the next reset).
//
// Ports:
//   i_sysclk     in   1   system clock (100 MHz), rising edge
//   i_sysrst     in   1   asynchronous active-high reset
//   o_init_cmd   out  4   {CS_n, RAS_n, CAS_n, WE_n}
//   o_init_ba    out  2   bank address
//   o_init_addr  out  13  address bus (A10 = all-banks flag)
//   o_init_done  out  1   initialisation complete
//
// state      | meaning
// -----------+--------------------------------------------------
// S_WAIT_PWR | power-up wait, NOP, T_POWER clocks
// S_PRE      | PRECHARGE ALL issue cycle
// S_TRP      | NOP gap after precharge, T_RP clocks
// S_AREF     | AUTO REFRESH issue cycle, bumps refresh counter
// S_TRFC     | NOP gap after refresh, T_RFC clocks
// S_MRS      | LOAD MODE REGISTER issue cycle
// S_TMRD     | NOP gap after mode register set, T_MRD clocks
// S_DONE     | terminal, init complete
//
// Outputs are registered decodes of the current state, so each command
// appears on the pins one cycle after the FSM enters its issue state.

module sdram_init_ctrl #(
    parameter int          T_POWER  = 20000,
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          T_MRD    = 3,
    parameter int          REF_NUM  = 8,
    parameter logic [12:0] MODE_REG = 13'b000_0_00_011_0_111
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst,
    output logic [3:0]  o_init_cmd,
    output logic [1:0]  o_init_ba,
    output logic [12:0] o_init_addr,
    output logic        o_init_done
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam int MAX_A = (T_POWER > T_RP)  ? T_POWER : T_RP;
    localparam int MAX_B = (T_RFC   > T_MRD) ? T_RFC   : T_MRD;
    localparam int MAX_T = (MAX_A   > MAX_B) ? MAX_A   : MAX_B;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int REF_W = $clog2(REF_NUM + 1);

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRFC,
        S_MRS,
        S_TMRD,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [REF_W-1:0]   ref_cnt;

    logic [3:0]         cmd_d;
    logic [1:0]         ba_d;
    logic [12:0]        addr_d;
    logic               done_d;

    logic               ref_full;
    assign ref_full = (ref_cnt == REF_W'(REF_NUM));

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            state   <= S_WAIT_PWR;
            cnt     <= '0;
            ref_cnt <= '0;
        end else begin
            state <= state_d;
            if (state_d != state)
                cnt <= '0;
            else if (state != S_DONE)
                cnt <= cnt + 1'b1;
            // Saturating: only reset may clear it.
            if (state == S_AREF && !ref_full)
                ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        cmd_d   = CMD_NOP;
        ba_d    = 2'b11;
        addr_d  = 13'h1FFF;
        done_d  = 1'b0;
        case (state)
            S_WAIT_PWR: begin
                if (cnt == CNT_W'(T_POWER - 1))
                    state_d = S_PRE;
            end
            S_PRE: begin
                cmd_d   = CMD_PRE;
                state_d = S_TRP;
            end
            S_TRP: begin
                if (cnt == CNT_W'(T_RP - 1))
                    state_d = S_AREF;
            end
            S_AREF: begin
                cmd_d   = CMD_AREF;
                state_d = S_TRFC;
            end
            S_TRFC: begin
                if (cnt == CNT_W'(T_RFC - 1))
                    state_d = ref_full ? S_MRS : S_AREF;
            end
            S_MRS: begin
                cmd_d   = CMD_LMR;
                ba_d    = 2'b00;
                addr_d  = MODE_REG;
                state_d = S_TMRD;
            end
            S_TMRD: begin
                if (cnt == CNT_W'(T_MRD - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: state_d = S_WAIT_PWR;
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            o_init_cmd  <= CMD_NOP;
            o_init_ba   <= 2'b11;
            o_init_addr <= 13'h1FFF;
            o_init_done <= 1'b0;
        end else begin
            o_init_cmd  <= cmd_d;
            o_init_ba   <= ba_d;
            o_init_addr <= addr_d;
            o_init_done <= done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Testbench for sdram_init_ctrl: default-parameter instance run through
// full sequences with mid-refresh and post-done resets, plus a small
// parameter override instance hit with randomly timed resets. Expected
// outputs come from a schedule model indexed by cycles since reset release.

module tb_sdram_init_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_big, rst_small;
    logic [3:0]  cmd_big, cmd_small;
    logic [1:0]  ba_big, ba_small;
    logic [12:0] addr_big, addr_small;
    logic        done_big, done_small;

    sdram_init_ctrl u_big (
        .i_sysclk    (clk),
        .i_sysrst    (rst_big),
        .o_init_cmd  (cmd_big),
        .o_init_ba   (ba_big),
        .o_init_addr (addr_big),
        .o_init_done (done_big)
    );

    sdram_init_ctrl #(
        .T_POWER (10),
        .T_RP    (1),
        .T_RFC   (1),
        .T_MRD   (1),
        .REF_NUM (2)
    ) u_small (
        .i_sysclk    (clk),
        .i_sysrst    (rst_small),
        .o_init_cmd  (cmd_small),
        .o_init_ba   (ba_small),
        .o_init_addr (addr_small),
        .o_init_done (done_small)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Schedule model: n = rising edges since release (0 = first edge).
    function automatic void model(input int n, input int tp, input int trp,
                                  input int trfc, input int tmrd, input int rn,
                                  output logic [3:0] c, output logic [1:0] b,
                                  output logic [12:0] a, output logic d);
        int a0, m;
        c  = 4'b0111;
        b  = 2'b11;
        a  = 13'h1FFF;
        d  = 1'b0;
        a0 = tp + 1 + trp;
        m  = a0 + rn * (1 + trfc);
        if (n == tp) c = 4'b0010;
        for (int k = 0; k < rn; k++)
            if (n == a0 + k * (1 + trfc)) c = 4'b0001;
        if (n == m) begin
            c = 4'b0000;
            b = 2'b00;
            a = 13'h0037;
        end
        if (n >= m + tmrd + 1) d = 1'b1;
    endfunction

    int n_big, n_small;
    always @(posedge clk or posedge rst_big)
        if (rst_big) n_big <= -1; else n_big <= n_big + 1;
    always @(posedge clk or posedge rst_small)
        if (rst_small) n_small <= -1; else n_small <= n_small + 1;

    int aref_big = 0;
    always @(negedge clk)
        if (!rst_big && cmd_big == 4'b0001) aref_big++;

    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    logic        e_done;

    // Per-cycle compare against the model, plus literal pins for defaults.
    always @(negedge clk) begin
        model(n_big, 20000, 2, 7, 3, 8, e_cmd, e_ba, e_addr, e_done);
        chk("big_cmd",  32'(cmd_big),  32'(e_cmd));
        chk("big_ba",   32'(ba_big),   32'(e_ba));
        chk("big_addr", 32'(addr_big), 32'(e_addr));
        chk("big_done", 32'(done_big), 32'(e_done));
        if (n_big == 20000) begin
            chk("pin_pre_cmd", 32'(cmd_big), 32'h2);
            chk("pin_pre_a10", 32'(addr_big[10]), 32'h1);
        end
        if (n_big == 20003) chk("pin_aref1", 32'(cmd_big), 32'h1);
        if (n_big == 20059) chk("pin_aref8", 32'(cmd_big), 32'h1);
        if (n_big == 20067) begin
            chk("pin_lmr_cmd",  32'(cmd_big),  32'h0);
            chk("pin_lmr_ba",   32'(ba_big),   32'h0);
            chk("pin_lmr_addr", 32'(addr_big), 32'h0037);
        end
        if (n_big == 20070) chk("pin_done_early", 32'(done_big), 32'h0);
        if (n_big == 20071) chk("pin_done_rise",  32'(done_big), 32'h1);

        model(n_small, 10, 1, 1, 1, 2, e_cmd, e_ba, e_addr, e_done);
        chk("small_cmd",  32'(cmd_small),  32'(e_cmd));
        chk("small_ba",   32'(ba_small),   32'(e_ba));
        chk("small_addr", 32'(addr_small), 32'(e_addr));
        chk("small_done", 32'(done_small), 32'(e_done));
        if (n_small == 10) chk("pin_s_pre",  32'(cmd_small), 32'h2);
        if (n_small == 12) chk("pin_s_aref", 32'(cmd_small), 32'h1);
        if (n_small == 14) chk("pin_s_aref", 32'(cmd_small), 32'h1);
        if (n_small == 16) chk("pin_s_lmr",  32'(cmd_small), 32'h0);
        if (n_small == 17) chk("pin_s_done0", 32'(done_small), 32'h0);
        if (n_small == 18) chk("pin_s_done1", 32'(done_small), 32'h1);
    end

    logic small_done = 1'b0;

    // Small instance: random reset release/assert points.
    initial begin
        rst_small = 1'b1;
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #3 rst_small = 1'b0;
            repeat ($urandom_range(30, 5)) @(posedge clk);
            #2 rst_small = 1'b1;
            #1;
            chk("small_async_cmd",  32'(cmd_small),  32'h7);
            chk("small_async_addr", 32'(addr_small), 32'h1FFF);
            chk("small_async_done", 32'(done_small), 32'h0);
        end
        @(posedge clk);
        #3 rst_small = 1'b0;
        repeat (30) @(posedge clk);
        small_done = 1'b1;
    end

    int base;

    initial begin
        rst_big = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_big = 1'b0;

        // Reset on the cycle the fifth AUTO REFRESH is on the pins.
        repeat (20036) @(posedge clk);
        #1 chk("mid_pre_cmd", 32'(cmd_big), 32'h1);
        #1 rst_big = 1'b1;
        #1;
        chk("async_mid_cmd",  32'(cmd_big),  32'h7);
        chk("async_mid_ba",   32'(ba_big),   32'h3);
        chk("async_mid_addr", 32'(addr_big), 32'h1FFF);

        repeat (2) @(posedge clk);
        #3 rst_big = 1'b0;
        base = aref_big;
        repeat (21072) @(posedge clk);
        #1;
        chk("aref_count_1", 32'(aref_big - base), 32'd8);
        chk("done_held",    32'(done_big), 32'h1);

        // Reset after done.
        #1 rst_big = 1'b1;
        #1 chk("async_done_clear", 32'(done_big), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_big = 1'b0;
        base = aref_big;
        repeat (20100) @(posedge clk);
        #1;
        chk("aref_count_2", 32'(aref_big - base), 32'd8);
        chk("done_again",   32'(done_big), 32'h1);

        for (int i = 0; i < 2000 && !small_done; i++) @(posedge clk);
        chk("small_finished", 32'(small_done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
